vmem_sequencer: RTL and testbench
=================================

VMEM_SEQUENCER -- requirements
Module: vmem_sequencer

Interface
- REQ-001: Parameter LANES, default 4, number of vector elements moved per memory instruction.
- REQ-002: Parameter ELEM_W, default 8, element width in bits.
- REQ-003: Parameter ADDR_W, default 32, memory address width.
- REQ-004: Parameter TIMEOUT, default 16, maximum cycles to wait for mem_ack on one element.
- REQ-005: One clock and a synchronous, active-high reset; ports are clk (input, 1, rising-edge clock) and rst (input, 1, synchronous active-high reset).
- REQ-006: start  input  1  memory-class instruction (type 2'b10) issued this cycle.
- REQ-007: is_store  input  1  instruction op bit; 1=STR, 0=LDR.
- REQ-008: base_addr  input  ADDR_W  ALU-computed base address.
- REQ-009: wdata_vec  input  LANES*ELEM_W  store vector; lane i at bits [i*ELEM_W +: ELEM_W].
- REQ-010: mem_req  output  1  element access request.
- REQ-011: mem_we  output  1  write enable qualifying mem_req.
- REQ-012: mem_addr  output  ADDR_W  element address.
- REQ-013: mem_wdata  output  ELEM_W  element store data.
- REQ-014: mem_ack  input  1  memory completed the current element.
- REQ-015: mem_rdata  input  ELEM_W  load data, valid with mem_ack.
- REQ-016: rdata_vec  output  LANES*ELEM_W  assembled load vector.
- REQ-017: stall  output  1  freeze the upstream pipeline.
- REQ-018: busy  output  1  sequencer not in IDLE.
- REQ-019: done  output  1  single-cycle pulse marking successful completion.
- REQ-020: err  output  1  single-cycle pulse marking a timeout abort.

Function
- REQ-021: The FSM SHALL have exactly three states: IDLE, XFER and DONE.
- REQ-022: In IDLE, start=1 SHALL latch is_store, base_addr and wdata_vec, clear the lane counter and the wait counter, and enter XFER next cycle.
- REQ-023: In XFER, mem_req SHALL be 1, mem_we SHALL equal the latched is_store, and mem_addr SHALL equal latched base + lane, wrapping modulo 2^ADDR_W.
- REQ-024: In XFER, mem_wdata SHALL equal latched lane element lane.
- REQ-025: mem_req, mem_addr, mem_we and mem_wdata SHALL stay stable until mem_ack.
- REQ-026: On mem_ack in XFER for a load, the sequencer SHALL write mem_rdata into rdata_vec lane slot at that edge.
- REQ-027: On mem_ack in XFER, the sequencer SHALL increment lane and clear the wait counter; if lane=LANES-1, it SHALL enter DONE instead of incrementing.
- REQ-028: Each XFER cycle without mem_ack SHALL increment the wait counter; when it reaches TIMEOUT-1 without mem_ack, the sequencer SHALL pulse err for 1 cycle and go to IDLE, leaving rdata_vec partially updated.
- REQ-029: DONE SHALL last 1 cycle, assert done=1 with mem_req=0, and return to IDLE.
- REQ-030: stall SHALL be combinational = (IDLE and start) or XFER, so the instruction is held from issue through the last ack and released in the DONE cycle.
- REQ-031: busy SHALL be 1 in XFER and DONE.
- REQ-032: start SHALL be ignored outside IDLE.
- REQ-033: mem_ack outside XFER SHALL be ignored.
- REQ-034: rdata_vec SHALL be unchanged by store transfers.
- REQ-035: Minimum latency SHALL be LANES+1 cycles from start to done with mem_ack tied high.

Reset
- REQ-036: rst=1 SHALL force IDLE with lane, wait counter, latched registers and rdata_vec all at 0.
- REQ-037: After rst=1, mem_req, mem_we, done, err, busy and stall SHALL all be 0 on the following cycle, including when reset arrives mid-XFER.
- REQ-038: rst SHALL take priority over start and mem_ack in the same cycle.

Structure
- REQ-039: The state enum (IDLE/XFER/DONE) and the memory-type code 2'b10 SHALL live in shared package vmem_defs, alongside alu_defs.
- REQ-040: The block SHALL be a single module with no sub-modules; the wait counter SHALL be sized $clog2(TIMEOUT).

Verification
- REQ-041: Load, base=0x10, mem_ack tied 1, memory returns 0xA0+addr-0x10 -> addrs 0x10..0x13, rdata_vec=0xA3A2A1A0, done at cycle 5.
- REQ-042: Store, base=0x20, wdata_vec=0xDDCCBBAA, ack every 3rd cycle -> writes AA@0x20, BB@0x21, CC@0x22, DD@0x23, outputs stable while waiting, stall high until DONE.
- REQ-043: base=0xFFFFFFFE load -> addrs 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
- REQ-044: start pulsed again during XFER with base=0x80 -> ignored; no access to 0x80.
- REQ-045: No ack for 16 cycles on lane 1 -> err pulse, IDLE, done never asserted.
- REQ-046: rst during lane 2 of a load -> next cycle mem_req=0, rdata_vec=0, busy=0.

Source files
------------

// File: rtl/vmem_defs.sv
`default_nettype none
// ============================================================================
// Module      : vmem_defs (package)
// Description : Shared definitions for the vector memory sequencer: FSM state
//               encoding and the memory-class instruction type code.
// Revision    : 1.0 - initial release
// ============================================================================
package vmem_defs;

    // Sequencer states; IDLE must stay 0 so a cleared register means idle.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } vmem_state_t;

    // Instruction type field value that identifies LDR/STR.
    localparam logic [1:0] c_type_mem = 2'b10;

endpackage
`default_nettype wire

// File: rtl/vmem_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : vmem_sequencer
// Description : Breaks one vector LDR/STR into LANES element-sized memory
//               accesses, stalls the pipeline while they run, assembles load
//               data and aborts with err when an element is never acked.
// Revision    : 1.0 - initial release
// ============================================================================
module vmem_sequencer
    import vmem_defs::*;
#(
    parameter int LANES   = 4,
    parameter int ELEM_W  = 8,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      is_store,
    input  logic [ADDR_W-1:0]         base_addr,
    input  logic [LANES*ELEM_W-1:0]   wdata_vec,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [ELEM_W-1:0]         mem_wdata,
    input  logic                      mem_ack,
    input  logic [ELEM_W-1:0]         mem_rdata,
    output logic [LANES*ELEM_W-1:0]   rdata_vec,
    output logic                      stall,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    // Guarded widths so single-lane / single-cycle builds still elaborate.
    localparam int c_lane_w = (LANES > 1)   ? $clog2(LANES)   : 1;
    localparam int c_wait_w = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    vmem_state_t               r_state;
    vmem_state_t               w_next_state;
    logic [c_lane_w-1:0]       r_lane;
    logic [c_wait_w-1:0]       r_wait;
    logic                      r_is_store;
    logic [ADDR_W-1:0]         r_base;
    logic [LANES*ELEM_W-1:0]   r_wdata;
    logic [LANES*ELEM_W-1:0]   r_rdata;
    logic [ELEM_W-1:0]         w_lane_wdata;
    logic                      w_last_lane;
    logic                      w_timeout;

    assign w_last_lane = (r_lane == c_lane_w'(LANES - 1));
    assign w_timeout   = (r_wait == c_wait_w'(TIMEOUT - 1));
    assign rdata_vec   = r_rdata;

    // Select the latched store element for the lane currently in flight.
    always_comb begin
        w_lane_wdata = '0;
        for (int i = 0; i < LANES; i++) begin
            if (r_lane == c_lane_w'(i)) begin
                w_lane_wdata = r_wdata[i*ELEM_W +: ELEM_W];
            end
        end
    end

    // State register; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and all control outputs, decoded from the current state.
    always_comb begin
        w_next_state = r_state;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        stall        = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        err          = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                stall = start;
                if (start) begin
                    w_next_state = ST_XFER;
                end
            end
            ST_XFER: begin
                mem_req   = 1'b1;
                mem_we    = r_is_store;
                mem_addr  = r_base + ADDR_W'(r_lane);
                mem_wdata = w_lane_wdata;
                stall     = 1'b1;
                busy      = 1'b1;
                if (mem_ack) begin
                    if (w_last_lane) begin
                        w_next_state = ST_DONE;
                    end
                end else if (w_timeout) begin
                    err          = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            ST_DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Instruction latch, lane/wait counters and load-vector assembly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lane     <= '0;
            r_wait     <= '0;
            r_is_store <= 1'b0;
            r_base     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_is_store <= is_store;
                        r_base     <= base_addr;
                        r_wdata    <= wdata_vec;
                        r_lane     <= '0;
                        r_wait     <= '0;
                    end
                end
                ST_XFER: begin
                    if (mem_ack) begin
                        if (!r_is_store) begin
                            for (int i = 0; i < LANES; i++) begin
                                if (r_lane == c_lane_w'(i)) begin
                                    r_rdata[i*ELEM_W +: ELEM_W] <= mem_rdata;
                                end
                            end
                        end
                        if (!w_last_lane) begin
                            r_lane <= r_lane + c_lane_w'(1);
                        end
                        r_wait <= '0;
                    end else if (w_timeout) begin
                        r_wait <= '0;
                    end else begin
                        r_wait <= r_wait + c_wait_w'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vmem_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_vmem_sequencer
// Description : Self-checking bench for vmem_sequencer: transaction-level
//               reference model compared every cycle, directed scenarios with
//               literal expectations, then randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vmem_sequencer;

    localparam int LANES   = 4;
    localparam int ELEM_W  = 8;
    localparam int ADDR_W  = 32;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_store;
    logic [31:0] base_addr;
    logic [31:0] wdata_vec;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic [31:0] rdata_vec;
    logic        stall;
    logic        busy;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    vmem_sequencer #(
        .LANES   (LANES),
        .ELEM_W  (ELEM_W),
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_store  (is_store),
        .base_addr (base_addr),
        .wdata_vec (wdata_vec),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .rdata_vec (rdata_vec),
        .stall     (stall),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    int n_pass = 0;
    int n_chk  = 0;

    // Reference model: an instruction in flight is (base, data, element k,
    // cycles waited w); fin marks the one completion cycle after the last ack.
    bit          m_x   = 1'b0;
    bit          m_fin = 1'b0;
    bit          m_st  = 1'b0;
    logic [31:0] m_base = '0;
    logic [31:0] m_wv   = '0;
    logic [31:0] m_rv   = '0;
    int          m_k = 0;
    int          m_w = 0;

    bit          rd_mode41 = 1'b0;
    logic [31:0] acc_addr[$];
    logic [7:0]  acc_data[$];
    int          n_done = 0;
    int          n_err  = 0;
    int          done_at = -1;
    int          cyc = 0;
    int          t0 = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    // Memory contents seen by loads.
    function automatic logic [7:0] rdfn(input logic [31:0] a);
        if (rd_mode41) return 8'(32'hA0 + a - 32'h10);
        return 8'(a * 32'd7 + 32'h3C);
    endfunction

    // One clock cycle: drive, compare against the model, advance the model.
    task automatic step(input bit st, input bit ist, input logic [31:0] ba,
                        input logic [31:0] wv, input bit ack, input bit r);
        logic [31:0] ea;
        logic [7:0]  rd;
        bit          e_err;
        start     = st;
        is_store  = ist;
        base_addr = ba;
        wdata_vec = wv;
        mem_ack   = ack;
        rst       = r;
        ea        = m_base + 32'(m_k);
        rd        = rdfn(ea);
        mem_rdata = rd;
        #1;
        e_err = m_x && !ack && (m_w == TIMEOUT - 1);
        chk("mem_req",   64'(mem_req),   64'(m_x));
        chk("busy",      64'(busy),      64'(m_x || m_fin));
        chk("stall",     64'(stall),     64'(m_x || (!m_fin && st)));
        chk("done",      64'(done),      64'(m_fin));
        chk("err",       64'(err),       64'(e_err));
        chk("rdata_vec", 64'(rdata_vec), 64'(m_rv));
        if (m_x) begin
            chk("mem_addr",  64'(mem_addr),  64'(ea));
            chk("mem_we",    64'(mem_we),    64'(m_st));
            chk("mem_wdata", 64'(mem_wdata), 64'(m_wv[8*m_k +: 8]));
        end
        if (mem_req && mem_ack) begin
            acc_addr.push_back(mem_addr);
            acc_data.push_back(mem_we ? mem_wdata : mem_rdata);
        end
        if (done) begin
            n_done++;
            done_at = cyc - t0;
        end
        if (err) n_err++;
        @(posedge clk);
        if (r) begin
            m_x = 0; m_fin = 0; m_st = 0; m_k = 0; m_w = 0;
            m_base = '0; m_wv = '0; m_rv = '0;
        end else if (m_fin) begin
            m_fin = 0;
        end else if (m_x) begin
            if (ack) begin
                if (!m_st) m_rv[8*m_k +: 8] = rd;
                if (m_k == LANES - 1) begin
                    m_x = 0; m_fin = 1;
                end else begin
                    m_k++; m_w = 0;
                end
            end else if (m_w == TIMEOUT - 1) begin
                m_x = 0;
            end else begin
                m_w++;
            end
        end else if (st) begin
            m_x = 1; m_st = ist; m_base = ba; m_wv = wv; m_k = 0; m_w = 0;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic new_test();
        acc_addr.delete();
        acc_data.delete();
        n_done  = 0;
        n_err   = 0;
        done_at = -1;
        t0      = cyc;
    endtask

    initial begin
        logic [31:0] exp_a[4];
        logic [7:0]  exp_d[4];
        int          starve;
        bit          hit80;

        rst = 1'b1; start = 1'b0; is_store = 1'b0; base_addr = '0;
        wdata_vec = '0; mem_ack = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_mem_we",    64'(mem_we),    64'd0);
        chk("reset_rdata_vec", 64'(rdata_vec), 64'd0);
        chk("reset_busy",      64'(busy),      64'd0);
        step(0, 0, 0, 0, 0, 0);

        // Load with ack tied high
        rd_mode41 = 1'b1;
        new_test();
        step(1, 0, 32'h10, 0, 1, 0);
        repeat (5) step(0, 0, 0, 0, 1, 0);
        exp_a = '{32'h10, 32'h11, 32'h12, 32'h13};
        chk("t41_count", 64'(acc_addr.size()), 64'd4);
        if (acc_addr.size() == 4)
            for (int i = 0; i < 4; i++) chk("t41_addr", 64'(acc_addr[i]), 64'(exp_a[i]));
        chk("t41_rdata_vec", 64'(rdata_vec), 64'h A3A2A1A0);
        chk("t41_latency",   64'(done_at),   64'd5);
        rd_mode41 = 1'b0;

        // Store, ack every third cycle
        new_test();
        step(1, 1, 32'h20, 32'hDDCCBBAA, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 0, 0, 0, (i % 3 == 2), 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        exp_a = '{32'h20, 32'h21, 32'h22, 32'h23};
        exp_d = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        chk("t42_count", 64'(acc_addr.size()), 64'd4);
        if (acc_addr.size() == 4)
            for (int i = 0; i < 4; i++) begin
                chk("t42_addr", 64'(acc_addr[i]), 64'(exp_a[i]));
                chk("t42_data", 64'(acc_data[i]), 64'(exp_d[i]));
            end
        chk("t42_rdata_kept", 64'(rdata_vec), 64'hA3A2A1A0);
        chk("t42_latency",    64'(done_at),   64'd13);

        // Address wrap at the top of memory
        new_test();
        step(1, 0, 32'hFFFF_FFFE, 0, 1, 0);
        repeat (5) step(0, 0, 0, 0, 1, 0);
        exp_a = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
        chk("t43_count", 64'(acc_addr.size()), 64'd4);
        if (acc_addr.size() == 4)
            for (int i = 0; i < 4; i++) chk("t43_addr", 64'(acc_addr[i]), 64'(exp_a[i]));

        // start re-pulsed during XFER must be ignored
        new_test();
        step(1, 0, 32'h30, 0, 0, 0);
        for (int i = 0; i < 10; i++) step((i < 7), 0, 32'h80, 0, (i % 2 == 1), 0);
        hit80 = 1'b0;
        foreach (acc_addr[i]) if (acc_addr[i] == 32'h80) hit80 = 1'b1;
        chk("t44_no_0x80", 64'(hit80),            64'd0);
        chk("t44_count",   64'(acc_addr.size()),  64'd4);
        chk("t44_done",    64'(n_done),           64'd1);

        // Timeout on lane 1
        new_test();
        step(1, 0, 32'h40, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        repeat (TIMEOUT) step(0, 0, 0, 0, 0, 0);
        repeat (2) step(0, 0, 0, 0, 0, 0);
        chk("t45_err",  64'(n_err),  64'd1);
        chk("t45_done", 64'(n_done), 64'd0);
        chk("t45_idle", 64'(busy),   64'd0);

        // Reset during lane 2 of a load
        new_test();
        step(1, 0, 32'h50, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 1);
        rst = 1'b0; mem_ack = 1'b0;
        #1;
        chk("t46_mem_req",   64'(mem_req),   64'd0);
        chk("t46_rdata_vec", 64'(rdata_vec), 64'd0);
        chk("t46_busy",      64'(busy),      64'd0);
        step(0, 0, 0, 0, 0, 0);

        // Randomized traffic
        starve = 0;
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] ba;
            bit          ack;
            ba = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFC | 32'($urandom_range(0, 3)))
                                             : $urandom;
            if (starve == 0 && $urandom_range(0, 99) == 0) starve = $urandom_range(10, 20);
            if (starve > 0) begin
                ack = 1'b0;
                starve--;
            end else begin
                ack = ($urandom_range(0, 9) < 6);
            end
            step(($urandom_range(0, 3) == 0), 1'($urandom), ba, $urandom, ack,
                 ($urandom_range(0, 199) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
